// File: rtl/t04_mmio_pkg.sv
// Shared constants for the MMIO request controller: FSM encodings,
// default address map and the layout of the keypad read word.
package t04_mmio_pkg;

  // state      | meaning
  // IDLE       | waiting for a datapath request
  // RAM_REQ    | wishbone strobe asserted, waiting for busy or timeout
  // RAM_WAIT   | wishbone transfer in flight, ack when busy drops
  // DISP       | display write in progress, ack on display_ack
  // KEY_ACK    | one-cycle keypad / unmapped access
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RAM_REQ  = 3'd1;
  localparam logic [2:0] ST_RAM_WAIT = 3'd2;
  localparam logic [2:0] ST_DISP     = 3'd3;
  localparam logic [2:0] ST_KEY_ACK  = 3'd4;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h3300_0000;
  localparam logic [31:0] RAM_MASK_DEF  = 32'hFF00_0000;
  localparam logic [31:0] DISP_ADDR_DEF = 32'hFFFF_FFFC;
  localparam logic [31:0] KEY_ADDR_DEF  = 32'hFFFF_FFF8;

  // Keypad read word: {22'b0, ovf, valid, code[7:0]}
  localparam int KEY_CODE_LSB  = 0;
  localparam int KEY_VALID_BIT = 8;
  localparam int KEY_OVF_BIT   = 9;

  function automatic logic [31:0] key_word(input logic ovf, input logic valid,
                                           input logic [7:0] code);
    return {22'b0, ovf, valid, code};
  endfunction

endpackage

// File: rtl/t04_key_buffer.sv
// Single-entry keypad code buffer. A new key overwrites the entry; a key
// arriving while the entry is still unread flags overflow. A load in the
// same cycle as a read-clear wins and starts a fresh, non-overflowed entry.
module t04_key_buffer (
  input  logic       clk,
  input  logic       nRst,
  input  logic       load_i,
  input  logic [7:0] code_i,
  input  logic       clear_i,
  output logic [7:0] code_o,
  output logic       valid_o,
  output logic       ovf_o
);

  logic [7:0] code_q;
  logic       valid_q;
  logic       ovf_q;

  // Entry register with load-over-clear priority.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load_i) begin
      code_q  <= code_i;
      valid_q <= 1'b1;
      ovf_q   <= clear_i ? 1'b0 : valid_q;
    end else if (clear_i) begin
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/t04_mmio_request_controller.sv
// Decodes datapath memory accesses into RAM (wishbone), display or keypad
// transactions and drives the qualifiers that let the downstream
// acknowledgement center produce exactly one d_ack per access.
module t04_mmio_request_controller
  import t04_mmio_pkg::*;
#(
  parameter logic [31:0] RAM_BASE    = RAM_BASE_DEF,
  parameter logic [31:0] RAM_MASK    = RAM_MASK_DEF,
  parameter logic [31:0] DISP_ADDR   = DISP_ADDR_DEF,
  parameter logic [31:0] KEY_ADDR    = KEY_ADDR_DEF,
  parameter int          REQ_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        busy,
  input  logic [31:0] wb_rdata,
  output logic        wb_ren,
  output logic        wb_wen,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic        disp_wen,
  output logic [31:0] disp_data,
  input  logic        display_ack,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        Ram_En,
  output logic        WEN,
  output logic        key_en
);

  localparam int            CW      = $clog2(REQ_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(REQ_TIMEOUT);
  localparam logic [CW-1:0] CNT_TO  = CW'(REQ_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0] kb_code;
  logic       kb_valid;
  logic       kb_ovf;
  logic       key_rd;

  // A keypad read clears the buffer in the same cycle it is returned.
  assign key_rd = (state_q == ST_KEY_ACK) && !wr_q && (addr_q == KEY_ADDR);

  t04_key_buffer u_key_buffer (
    .clk     (clk),
    .nRst    (nRst),
    .load_i  (key_valid),
    .code_i  (key_code),
    .clear_i (key_rd),
    .code_o  (kb_code),
    .valid_o (kb_valid),
    .ovf_o   (kb_ovf)
  );

  // Next-state logic: registered decode in IDLE, sequencing elsewhere.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wr_d    = MemWrite;
          if ((mem_addr & RAM_MASK) == (RAM_BASE & RAM_MASK)) begin
            state_d = ST_RAM_REQ;
            cnt_d   = '0;
          end else if (mem_addr == DISP_ADDR) begin
            state_d = ST_DISP;
          end else begin
            state_d = ST_KEY_ACK;
          end
        end
      end
      ST_RAM_REQ: begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        if (busy || (cnt_q >= CNT_TO)) state_d = ST_RAM_WAIT;
      end
      ST_RAM_WAIT: begin
        if (!busy) state_d = ST_IDLE;
      end
      ST_DISP: begin
        if (display_ack) state_d = ST_IDLE;
      end
      ST_KEY_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request latches; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output muxes: everything idles at 0 outside its owning state.
  always_comb begin
    mem_rdata = 32'h0;
    wb_ren    = 1'b0;
    wb_wen    = 1'b0;
    disp_wen  = 1'b0;
    disp_data = 32'h0;
    Ram_En    = 1'b0;
    WEN       = 1'b0;
    key_en    = 1'b0;
    case (state_q)
      ST_RAM_REQ: begin
        wb_wen = wr_q;
        wb_ren = !wr_q;
      end
      ST_RAM_WAIT: begin
        Ram_En = 1'b1;
        if (!busy) mem_rdata = wb_rdata;
      end
      ST_DISP: begin
        WEN       = 1'b1;
        disp_wen  = wr_q;
        disp_data = wdata_q;
      end
      ST_KEY_ACK: begin
        key_en = 1'b1;
        if (key_rd) mem_rdata = key_word(kb_ovf, kb_valid, kb_code);
      end
      default: begin
      end
    endcase
  end

  assign wb_addr  = addr_q;
  assign wb_wdata = wdata_q;

endmodule

// File: tb/tb_t04_mmio_request_controller.sv
// Directed bench for t04_mmio_request_controller. Stimulus pushes the expected
// ack cycle and read data into a scoreboard; a negedge monitor models the
// acknowledgement center's d_ack and pops/compares on every ack.
module tb_t04_mmio_request_controller;

  localparam logic [31:0] KEY  = 32'hFFFF_FFF8;
  localparam logic [31:0] DISP = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        nRst;
  logic        MemRead, MemWrite;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic [31:0] wb_rdata;
  logic        wb_ren, wb_wen;
  logic [31:0] wb_addr, wb_wdata;
  logic        disp_wen;
  logic [31:0] disp_data;
  logic        display_ack;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        Ram_En, WEN, key_en;
  logic        d_ack;

  t04_mmio_request_controller dut (
    .clk(clk), .nRst(nRst), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .wb_rdata(wb_rdata), .wb_ren(wb_ren), .wb_wen(wb_wen),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .disp_wen(disp_wen),
    .disp_data(disp_data), .display_ack(display_ack), .key_valid(key_valid),
    .key_code(key_code), .Ram_En(Ram_En), .WEN(WEN), .key_en(key_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Acknowledgement-center model
  assign d_ack = (Ram_En & ~busy) | (WEN & display_ack) | key_en;

  always @(negedge clk) begin
    if (nRst && d_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_rdata", mem_rdata, e.rdata);
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [31:0] r);
    exp_t x;
    x.cyc   = c;
    x.rdata = r;
    sb.push_back(x);
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d);
    MemRead   = rd;
    MemWrite  = wr;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  task automatic idle_in();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic key_press(input logic [7:0] c);
    nc();
    key_valid = 1'b1;
    key_code  = c;
    nc();
    key_valid = 1'b0;
  endtask

  // One-cycle access (keypad or unmapped): ack expected at N+1.
  task automatic simple_acc(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd);
    int n;
    nc();
    req(rd, wr, a, d);
    n = cyc;
    push(n + 1, exp_rd);
    nc();
    #1 chk("key_en_pulse", key_en, 1'b1);
    nc();
    idle_in();
    #1 chk("key_en_drop", key_en, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    nRst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_addr = 32'h0;
    mem_wdata = 32'h0; busy = 1'b0; wb_rdata = 32'h0; display_ack = 1'b0;
    key_valid = 1'b0; key_code = 8'h0;
    nc();
    nc();
    #1;
    chk("rst_wb_ren", wb_ren, 1'b0);
    chk("rst_wb_wen", wb_wen, 1'b0);
    chk("rst_ram_en", Ram_En, 1'b0);
    chk("rst_wen", WEN, 1'b0);
    chk("rst_key_en", key_en, 1'b0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_wb_addr", wb_addr, 32'h0);
    chk("rst_disp_wen", disp_wen, 1'b0);
    nc();
    nRst = 1'b1;

    // RAM read, busy high N+2..N+4
    nc();
    req(1'b1, 1'b0, 32'h3300_0010, 32'h0);
    wb_rdata = 32'hDEAD_BEEF;
    n = cyc;
    push(n + 5, 32'hDEAD_BEEF);
    nc();
    #1 chk("rd_wb_ren_n1", wb_ren, 1'b1);
    chk("rd_ram_en_n1", Ram_En, 1'b0);
    nc();
    busy = 1'b1;
    #1 chk("rd_wb_ren_n2", wb_ren, 1'b1);
    nc();
    #1 chk("rd_wb_ren_n3", wb_ren, 1'b0);
    chk("rd_ram_en_n3", Ram_En, 1'b1);
    chk("rd_wb_addr", wb_addr, 32'h3300_0010);
    nc();
    nc();
    busy = 1'b0;
    nc();
    idle_in();
    #1 chk("rd_idle_n6", Ram_En, 1'b0);

    // RAM write, busy never rises: timeout path
    nc();
    req(1'b0, 1'b1, 32'h3300_0020, 32'h1234_5678);
    wb_rdata = 32'h0;
    n = cyc;
    push(n + 5, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      nc();
      #1 chk("wr_wb_wen", wb_wen, 1'b1);
      chk("wr_wb_ren", wb_ren, 1'b0);
      chk("wr_ram_en_early", Ram_En, 1'b0);
    end
    nc();
    #1 chk("wr_wb_wen_n5", wb_wen, 1'b0);
    chk("wr_ram_en_n5", Ram_En, 1'b1);
    chk("wr_wb_wdata", wb_wdata, 32'h1234_5678);
    nc();
    idle_in();
    #1 chk("wr_idle_n6", Ram_En, 1'b0);

    // Display write, display_ack at N+3
    nc();
    req(1'b0, 1'b1, DISP, 32'h0000_00AA);
    n = cyc;
    push(n + 3, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      nc();
      display_ack = (i == 3);
      #1 chk("disp_wen", disp_wen, 1'b1);
      chk("disp_data", disp_data, 32'h0000_00AA);
      chk("disp_WEN", WEN, 1'b1);
    end
    nc();
    display_ack = 1'b0;
    idle_in();
    #1 chk("disp_WEN_drop", WEN, 1'b0);
    chk("disp_wen_drop", disp_wen, 1'b0);

    // Two keys before a read: overflow, then cleared
    key_press(8'h35);
    key_press(8'h36);
    simple_acc(1'b1, 1'b0, KEY, 32'h0, 32'h0000_0336);
    simple_acc(1'b1, 1'b0, KEY, 32'h0, 32'h0000_0000);

    // Key arriving in the same cycle as the read-clear
    key_press(8'h41);
    nc();
    req(1'b1, 1'b0, KEY, 32'h0);
    n = cyc;
    push(n + 1, 32'h0000_0141);
    nc();
    key_valid = 1'b1;
    key_code  = 8'h42;
    #1 chk("coinc_key_en", key_en, 1'b1);
    nc();
    key_valid = 1'b0;
    idle_in();
    simple_acc(1'b1, 1'b0, KEY, 32'h0, 32'h0000_0142);
    simple_acc(1'b1, 1'b0, KEY, 32'h0, 32'h0000_0000);

    // Unmapped accesses and write-to-keypad leave the buffer alone
    key_press(8'h55);
    simple_acc(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
    simple_acc(1'b0, 1'b1, 32'h0000_0200, 32'h0000_FFFF, 32'h0);
    simple_acc(1'b1, 1'b1, KEY, 32'h0, 32'h0);
    simple_acc(1'b1, 1'b0, KEY, 32'h0, 32'h0000_0155);

    // Reset during RAM_WAIT
    key_press(8'h77);
    nc();
    req(1'b1, 1'b0, 32'h3300_0040, 32'h0);
    wb_rdata = 32'h0BAD_F00D;
    nc();
    busy = 1'b1;
    nc();
    nc();
    #1 chk("rst_mid_ram_en", Ram_En, 1'b1);
    nRst = 1'b0;
    idle_in();
    nc();
    nRst = 1'b1;
    busy = 1'b0;
    #1 chk("rstm_ram_en", Ram_En, 1'b0);
    chk("rstm_wb_ren", wb_ren, 1'b0);
    chk("rstm_wb_wen", wb_wen, 1'b0);
    chk("rstm_wb_addr", wb_addr, 32'h0);
    chk("rstm_wb_wdata", wb_wdata, 32'h0);
    chk("rstm_mem_rdata", mem_rdata, 32'h0);
    chk("rstm_key_en", key_en, 1'b0);
    chk("rstm_wen", WEN, 1'b0);
    chk("rstm_disp_wen", disp_wen, 1'b0);
    chk("rstm_disp_data", disp_data, 32'h0);
    simple_acc(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0);
    simple_acc(1'b1, 1'b0, KEY, 32'h0, 32'h0);

    nc();
    nc();
    nc();
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
